// File: rtl/polar_pkg.sv
// Shared state encoding and bit-index helpers for the polar SC decoder scheduler.
package polar_pkg;

   localparam int FW = 12;

   typedef enum logic [5:0] {
      ST_IDLE   = 6'b000001,
      ST_INPUT  = 6'b000010,
      ST_LLR    = 6'b000100,
      ST_DECIDE = 6'b001000,
      ST_PSUM   = 6'b010000,
      ST_OUT    = 6'b100000
   } state_t;

   function automatic logic [3:0] trailing_zeros(input logic [FW-1:0] v);
      logic [3:0] n;
      logic       hit;
      n   = '0;
      hit = 1'b0;
      for (int k = 0; k < FW; k++) begin
         if (!hit) begin
            if (v[k]) hit = 1'b1;
            else      n   = n + 4'd1;
         end
      end
      return n;
   endfunction

   function automatic logic [3:0] trailing_ones(input logic [FW-1:0] v);
      return trailing_zeros(~v);
   endfunction

endpackage

// File: rtl/polar_stage_walker.sv
// Walks a tree stage range one step at a time, dwelling STAGE_LAT cycles per stage
// and strobing op_en on the first cycle of each; done flags the final dwell cycle.
module polar_stage_walker
   import polar_pkg::*;
#(
   parameter int SW        = 2,
   parameter int STAGE_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          go,
   input  logic          dir_up,
   input  logic [SW-1:0] start_stage,
   input  logic [SW-1:0] end_stage,
   output logic [SW-1:0] stage,
   output logic          op_en,
   output logic          done
);

   localparam int CW = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
   localparam logic [CW-1:0] LAST_DWELL = CW'(STAGE_LAT - 1);

   logic          active;
   logic          up_q;
   logic [SW-1:0] end_q;
   logic [CW-1:0] dwell;
   logic          last_cycle;

   assign last_cycle = active && (dwell == LAST_DWELL);
   assign done       = last_cycle && (stage == end_q);

   // go wins over done so the next walk starts with no bubble cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
         up_q   <= 1'b0;
         end_q  <= '0;
         dwell  <= '0;
         stage  <= '0;
         op_en  <= 1'b0;
      end else if (go) begin
         active <= 1'b1;
         up_q   <= dir_up;
         end_q  <= end_stage;
         dwell  <= '0;
         stage  <= start_stage;
         op_en  <= 1'b1;
      end else if (last_cycle) begin
         dwell <= '0;
         if (stage == end_q) begin
            active <= 1'b0;
            op_en  <= 1'b0;
         end else begin
            stage <= up_q ? stage + SW'(1) : stage - SW'(1);
            op_en <= 1'b1;
         end
      end else begin
         op_en <= 1'b0;
         if (active) dwell <= dwell + CW'(1);
      end
   end

endmodule

// File: rtl/polar_sc_scheduler.sv
// Successive-cancellation polar decoder control: input load, LLR/decide/partial-sum
// tree walk, output drain. Define POLAR_TLAST_CHECK_EN to enable s_tlast framing checks.
module polar_sc_scheduler
   import polar_pkg::*;
#(
   parameter int LOG2_N    = 10,
   parameter int STAGE_LAT = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        s_tvalid,
   input  logic                        s_tlast,
   output logic                        s_tready,
   output logic                        in_we,
   output logic [LOG2_N-1:0]           in_addr,
   output logic [$clog2(LOG2_N)-1:0]   stage,
   output logic [LOG2_N-1:0]           bit_idx,
   output logic                        llr_op_en,
   output logic                        psum_op_en,
   output logic                        dec_en,
   input  logic                        frozen,
   input  logic                        m_tready,
   output logic                        m_tvalid,
   output logic                        m_tlast,
   output logic [LOG2_N-1:0]           out_addr,
   output logic [5:0]                  state_out,
   output logic                        err
);

   localparam int SW = $clog2(LOG2_N);
   localparam logic [LOG2_N-1:0] LAST_IDX = {LOG2_N{1'b1}};

   state_t            state;
   logic              beat;
   logic              walk_go;
   logic              walk_up;
   logic [SW-1:0]     walk_start;
   logic [SW-1:0]     walk_end;
   logic              walk_op;
   logic              walk_done;
   logic [LOG2_N-1:0] next_bit;
   logic [3:0]        t_ones;
   logic [3:0]        tz_next;
   logic              unused;

   assign s_tready   = (state == ST_INPUT);
   assign beat       = s_tready && s_tvalid;
   assign in_we      = beat;
   assign llr_op_en  = walk_op && (state == ST_LLR);
   assign psum_op_en = walk_op && (state == ST_PSUM);
   assign dec_en     = (state == ST_DECIDE);
   assign m_tvalid   = (state == ST_OUT);
   assign m_tlast    = (state == ST_OUT) && (out_addr == LAST_IDX);
   assign state_out  = state;

   // start(i+1) equals the trailing-ones count of i, so one lookup serves both paths
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      walk_go    = 1'b0;
      walk_up    = 1'b0;
      walk_start = '0;
      walk_end   = '0;
      next_bit   = bit_idx + LOG2_N'(1);
      t_ones     = trailing_ones(FW'(bit_idx));
      tz_next    = trailing_zeros(FW'(next_bit));
      case (state)
         ST_INPUT: begin
            if (beat && in_addr == LAST_IDX) begin
               walk_go    = 1'b1;
               walk_start = SW'(LOG2_N - 1);
            end
         end
         ST_DECIDE: begin
            if (bit_idx != LAST_IDX) begin
               walk_go = 1'b1;
               if (t_ones == 4'd0) begin
                  walk_start = SW'(tz_next);
               end else begin
                  walk_up  = 1'b1;
                  walk_end = SW'(t_ones - 4'd1);
               end
            end
         end
         ST_PSUM: begin
            if (walk_done) begin
               walk_go    = 1'b1;
               walk_start = SW'(tz_next);
            end
         end
         default: ;
      endcase
   end

   polar_stage_walker #(
      .SW        (SW),
      .STAGE_LAT (STAGE_LAT)
   ) u_walker (
      .clk         (clk),
      .reset       (reset),
      .go          (walk_go),
      .dir_up      (walk_up),
      .start_stage (walk_start),
      .end_stage   (walk_end),
      .stage       (stage),
      .op_en       (walk_op),
      .done        (walk_done)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state    <= ST_IDLE;
         in_addr  <= '0;
         bit_idx  <= '0;
         out_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (s_tvalid) state <= ST_INPUT;
            end
            ST_INPUT: begin
               if (beat) begin
                  if (in_addr == LAST_IDX) begin
                     state   <= ST_LLR;
                     bit_idx <= '0;
                  end else begin
                     in_addr <= in_addr + LOG2_N'(1);
                  end
               end
            end
            ST_LLR: begin
               if (walk_done) state <= ST_DECIDE;
            end
            ST_DECIDE: begin
               if (bit_idx == LAST_IDX) begin
                  state    <= ST_OUT;
                  out_addr <= '0;
               end else if (t_ones == 4'd0) begin
                  bit_idx <= next_bit;
                  state   <= ST_LLR;
               end else begin
                  state <= ST_PSUM;
               end
            end
            ST_PSUM: begin
               if (walk_done) begin
                  bit_idx <= next_bit;
                  state   <= ST_LLR;
               end
            end
            ST_OUT: begin
               if (m_tready) begin
                  if (out_addr == LAST_IDX) begin
                     state    <= ST_IDLE;
                     in_addr  <= '0;
                     bit_idx  <= '0;
                     out_addr <= '0;
                  end else begin
                     out_addr <= out_addr + LOG2_N'(1);
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_addr  <= '0;
               bit_idx  <= '0;
               out_addr <= '0;
            end
         endcase
      end
   end

   // frozen is consumed by the datapath's decision logic, not by this controller
`ifdef POLAR_TLAST_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)
         err <= 1'b0;
      else if (beat && (s_tlast != (in_addr == LAST_IDX)))
         err <= 1'b1;
   end
   assign unused = frozen;
`else
   assign err    = 1'b0;
   assign unused = ^{frozen, s_tlast};
`endif

endmodule

// File: tb/tb_polar_sc_scheduler.sv
// Self-checking bench for polar_sc_scheduler (N=8, STAGE_LAT=3) against a per-cycle
// schedule derived from the SC tree-walk rules.
module tb_polar_sc_scheduler;

   localparam int L   = 3;
   localparam int N   = 1 << L;
   localparam int LAT = 3;
   localparam int S_IDLE = 1, S_LLR = 4, S_DEC = 8, S_PSUM = 16, S_OUT = 32;

`ifdef POLAR_TLAST_CHECK_EN
   localparam bit CHECK_ON = 1'b1;
`else
   localparam bit CHECK_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         s_tvalid, s_tlast, s_tready;
   logic         in_we;
   logic [L-1:0] in_addr;
   logic [1:0]   stage;
   logic [L-1:0] bit_idx;
   logic         llr_op_en, psum_op_en, dec_en;
   logic         frozen;
   logic         m_tready, m_tvalid, m_tlast;
   logic [L-1:0] out_addr;
   logic [5:0]   state_out;
   logic         err;

   int checks   = 0;
   int failures = 0;
   bit err_exp  = 1'b0;

   typedef struct {
      int st;
      int stg;
      int bi;
      bit llr;
      bit psum;
      bit dec;
   } ev_t;
   ev_t trace[$];

   always #5 clk = ~clk;

   polar_sc_scheduler #(.LOG2_N(L), .STAGE_LAT(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .s_tvalid   (s_tvalid),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .in_we      (in_we),
      .in_addr    (in_addr),
      .stage      (stage),
      .bit_idx    (bit_idx),
      .llr_op_en  (llr_op_en),
      .psum_op_en (psum_op_en),
      .dec_en     (dec_en),
      .frozen     (frozen),
      .m_tready   (m_tready),
      .m_tvalid   (m_tvalid),
      .m_tlast    (m_tlast),
      .out_addr   (out_addr),
      .state_out  (state_out),
      .err        (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int tz(input int v);
      int n = 0;
      while (v % 2 == 0 && n < L) begin v = v / 2; n++; end
      return n;
   endfunction

   function automatic int tones(input int v);
      int n = 0;
      while (v % 2 == 1) begin v = v / 2; n++; end
      return n;
   endfunction

   // Expected cycle-by-cycle schedule from the first LLR cycle to the last decision
   function automatic void build_trace();
      trace.delete();
      for (int i = 0; i < N; i++) begin
         int s = (i == 0) ? L - 1 : tz(i);
         for (int st = s; st >= 0; st--)
            for (int c = 0; c < LAT; c++)
               trace.push_back('{S_LLR, st, i, c == 0, 1'b0, 1'b0});
         trace.push_back('{S_DEC, -1, i, 1'b0, 1'b0, 1'b1});
         if (i < N - 1)
            for (int st = 0; st < tones(i); st++)
               for (int c = 0; c < LAT; c++)
                  trace.push_back('{S_PSUM, st, i, 1'b0, c == 0, 1'b0});
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"},    32'(state_out),  S_IDLE);
      check({tag, "_in_addr"},  32'(in_addr),    0);
      check({tag, "_bit_idx"},  32'(bit_idx),    0);
      check({tag, "_out_addr"}, 32'(out_addr),   0);
      check({tag, "_stage"},    32'(stage),      0);
      check({tag, "_strobes"},  32'({llr_op_en, psum_op_en, dec_en, in_we}), 0);
      check({tag, "_handshk"},  32'({s_tready, m_tvalid, m_tlast}), 0);
   endtask

   task automatic send_frame(input int bad_beat);
      for (int b = 0; b < N; b++) begin
         int gap = $urandom_range(0, 2);
         repeat (gap) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            @(negedge clk);
            check("gap_in_we", 32'(in_we), 0);
            step();
         end
         s_tvalid = 1'b1;
         s_tlast  = (bad_beat >= 0) ? (b == bad_beat) : (b == N - 1);
         begin
            int w = 0;
            @(negedge clk);
            while (!s_tready && w < 4) begin
               step();
               @(negedge clk);
               w++;
            end
         end
         check("beat_s_tready", 32'(s_tready), 1);
         check("beat_in_we",    32'(in_we),    1);
         check("beat_in_addr",  32'(in_addr),  32'(b));
         check("beat_err",      32'(err),      32'(err_exp));
         if (CHECK_ON && (s_tlast != (b == N - 1))) err_exp = 1'b1;
         step();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // abort=1 asserts reset in the first PSUM cycle of bit 3 and checks the recovery state
   task automatic run_decode(input bit abort);
      foreach (trace[k]) begin
         frozen = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("dec_state",  32'(state_out),  32'(trace[k].st));
         check("dec_bit",    32'(bit_idx),    32'(trace[k].bi));
         check("dec_llr_op", 32'(llr_op_en),  32'(trace[k].llr));
         check("dec_psum",   32'(psum_op_en), 32'(trace[k].psum));
         check("dec_dec_en", 32'(dec_en),     32'(trace[k].dec));
         if (trace[k].st != S_DEC)
            check("dec_stage", 32'(stage), 32'(trace[k].stg));
         if (abort && trace[k].st == S_PSUM && trace[k].bi == 3) begin
            reset = 1'b1;
            step();
            reset   = 1'b0;
            err_exp = 1'b0;
            @(negedge clk);
            check_idle("mid_reset");
            check("mid_reset_err", 32'(err), 0);
            step();
            return;
         end
         step();
      end
      @(negedge clk);
      check("out_entry_state",    32'(state_out), S_OUT);
      check("out_entry_out_addr", 32'(out_addr),  0);
      check("out_entry_in_addr",  32'(in_addr),   N - 1);
      check("out_entry_bit_idx",  32'(bit_idx),   N - 1);
      check("out_entry_err",      32'(err),       32'(err_exp));
      step();
   endtask

   task automatic run_out(input bit patterned);
      bit pat[4];
      int transfers = 0;
      int cyc = 0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      while (transfers < N && cyc < 200) begin
         m_tready = patterned ? pat[cyc % 4] : 1'($urandom_range(0, 1));
         @(negedge clk);
         check("out_state",    32'(state_out), S_OUT);
         check("out_m_tvalid", 32'(m_tvalid),  1);
         check("out_addr",     32'(out_addr),  32'(transfers));
         check("out_m_tlast",  32'(m_tlast),   32'(transfers == N - 1));
         if (m_tready) transfers++;
         step();
         cyc++;
      end
      if (transfers < N) check("out_timeout", 32'(transfers), N);
      m_tready = 1'b0;
      @(negedge clk);
      check_idle("after_out");
      step();
   endtask

   initial begin
      reset    = 1'b1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      frozen   = 1'b0;
      m_tready = 1'b0;
      build_trace();
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_idle("reset");
      check("reset_err", 32'(err), 0);
      step();
      reset = 1'b0;

      repeat (2) begin
         @(negedge clk);
         check("idle_hold_state",    32'(state_out), S_IDLE);
         check("idle_hold_s_tready", 32'(s_tready),  0);
         step();
      end

      // Frame 1: clean framing, toggling output back-pressure
      send_frame(-1);
      run_decode(1'b0);
      run_out(1'b1);

      // Frame 2: premature s_tlast on beat 5, then reset mid-PSUM at bit 3
      send_frame(5);
      run_decode(1'b1);

      // Frame 3: fresh frame after the mid-frame reset must decode identically
      send_frame(-1);
      run_decode(1'b0);
      run_out(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/polar_sc_scheduler.md
POLAR_SC_SCHEDULER -- requirements
Module: polar_sc_scheduler

Interface
REQ-001 SHALL have parameter LOG2_N, default 10, log2 of code length N (N = 2**LOG2_N, LOG2_N 2..12).
REQ-002 SHALL have parameter STAGE_LAT, default 2, cycles per LLR or partial-sum stage operation (1..4).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports s_tvalid / s_tlast  input  1 / 1  channel-LLR stream valid / frame end.
REQ-006 SHALL have port s_tready  output  1  LLR stream ready.
REQ-007 SHALL have ports in_we / in_addr  output  1 / LOG2_N  channel-LLR RAM write enable / address.
REQ-008 SHALL have ports stage / bit_idx  output  $clog2(LOG2_N) / LOG2_N  current tree stage / current decoded-bit index.
REQ-009 SHALL have ports llr_op_en / psum_op_en / dec_en  output  1 each  one-cycle datapath strobes.
REQ-010 SHALL have port frozen  input  1  frozen flag for bit_idx, from the external frozen-set ROM.
REQ-011 SHALL have ports m_tready  input  1; m_tvalid / m_tlast  output  1 / 1; out_addr  output  LOG2_N.
REQ-012 SHALL have ports state_out  output  6  one-hot state; err  output  1  sticky framing error.

Function
REQ-013 SHALL use one-hot states IDLE=1, INPUT=2, LLR=4, DECIDE=8, PSUM=16, OUT=32; any other encoding returns to IDLE on the next edge.
REQ-014 IDLE SHALL hold s_tready=0 and go to INPUT when s_tvalid=1.
REQ-015 INPUT SHALL drive s_tready=1; each beat (s_tvalid&s_tready) pulses in_we with in_addr = beat count 0..N-1; after beat N-1, go to LLR with bit_idx=0.
REQ-016 LLR SHALL step stage from start(i) down to 0, holding each stage STAGE_LAT cycles and pulsing llr_op_en on the first of them; start(0)=LOG2_N-1, start(i)=trailing zeros of i for i>0; after stage 0, go to DECIDE.
REQ-017 DECIDE SHALL last one cycle with dec_en=1 (datapath forces bit to 0 when frozen=1; the controller passes frozen through unchanged).
REQ-018 After DECIDE with bit_idx=N-1, SHALL go to OUT with out_addr=0.
REQ-019 After DECIDE with bit_idx<N-1: t = trailing ones of bit_idx; t=0 -> bit_idx+1 and LLR; t>0 -> PSUM.
REQ-020 PSUM SHALL step stage 0..t-1, STAGE_LAT cycles each, pulsing psum_op_en on the first; then increment bit_idx and go to LLR.
REQ-021 OUT SHALL hold m_tvalid=1; each handshake advances out_addr; m_tlast=1 when out_addr=N-1; handshake at N-1 -> IDLE.
REQ-022 m_tvalid SHALL NOT drop while m_tready=0.
REQ-023 bit_idx, in_addr, out_addr SHALL never wrap mid-frame; all three reset to 0 on entering IDLE.

Reset
REQ-024 reset=1 at any clock edge, including mid-frame, SHALL force IDLE; outputs 0 except state_out=6'b000001; err cleared.
REQ-025 No output SHALL depend combinationally on reset.

Configuration
REQ-026 With POLAR_TLAST_CHECK_EN defined: err SHALL set when s_tlast=1 on a beat other than N-1, or s_tlast=0 on beat N-1; beat count unaffected; err held until reset.
REQ-027 Without POLAR_TLAST_CHECK_EN: s_tlast ignored; err tied to 0.

Structure
REQ-028 State encodings and a trailing-zeros/trailing-ones function SHALL live in shared package polar_pkg.
REQ-029 Stage stepping plus STAGE_LAT dwell SHALL be one sub-module, polar_stage_walker (start, end, direction, go -> stage, op_en, done), used by LLR and PSUM.

Verification
REQ-030 LOG2_N=3, STAGE_LAT=1: llr_op_en stage sequence 2,1,0 | 0 | 1,0 | 0 | 2,1,0 | 0 | 1,0 | 0 across bits 0..7 (14 pulses).
REQ-031 Same config: psum_op_en stages 0 after bit1; 0,1 after bit3; 0 after bit5; none after bits 0,2,4,6,7; 26 cycles from first LLR to OUT.
REQ-032 STAGE_LAT=3: each stage held 3 cycles, one strobe per stage; decode span 14*3+8+4*3=62 cycles.
REQ-033 OUT with m_tready toggling 1,0,0,1...: exactly 8 transfers, m_tvalid never drops, m_tlast only at out_addr=7, then IDLE.
REQ-034 reset asserted in PSUM at bit 3: next cycle state_out=1, all counters 0; fresh frame decodes identically to REQ-030.
REQ-035 POLAR_TLAST_CHECK_EN: s_tlast on beat 5 of 8 -> err=1 from next cycle, input still accepts 8 beats; without macro err stays 0.
